alu_share_arbiter: RTL and testbench

- Shares one 32-bit ALU instance between NUM_REQ requesters, e.g. the core datapath and a branch/address-generation helper.
- Arbitrates, latches the winner's operands, drives the ALU for one execute cycle, captures result/zero, and returns them to the winner over a valid/ready response handshake.
- Sits between requesters and the ALU; the ALU stays a separate instance wired to the alu_* ports.

---
 rtl/alu_share_arbiter.sv | 157 +++++++++++++++
 tb/tb_alu_share_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between NUM_REQ requesters: arbitrate, latch operands, execute, return result.
// Accept-to-response is 2 cycles; one op in flight, so req_ready stays low until the response is consumed.
// Optional round-robin arbitration via ALU_ARB_ROUND_ROBIN_EN (fixed lowest-index priority otherwise).
module alu_share_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4,
  parameter int ID_WIDTH   = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  input  logic [NUM_REQ*OP_WIDTH-1:0]      req_op_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_a_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_b_i,
  output logic [NUM_REQ-1:0]               rsp_valid_o,
  input  logic [NUM_REQ-1:0]               rsp_ready_i,
  output logic [DATA_WIDTH-1:0]            rsp_result_o,
  output logic                             rsp_zero_o,
  output logic [ID_WIDTH-1:0]              grant_id_o,
  output logic                             busy_o,
  output logic [OP_WIDTH-1:0]              alu_op_o,
  output logic [DATA_WIDTH-1:0]            alu_a_o,
  output logic [DATA_WIDTH-1:0]            alu_b_o,
  input  logic [DATA_WIDTH-1:0]            alu_result_i,
  input  logic                             alu_zero_i
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_EXEC = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

  logic [1:0]            state_q;
  logic [ID_WIDTH-1:0]   grant_q;
  logic [OP_WIDTH-1:0]   op_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  zero_q;

  logic                  any_vld;
  logic [ID_WIDTH-1:0]   win_id;
  logic [NUM_REQ-1:0]    win_oh;
  logic [NUM_REQ-1:0]    grant_oh;
  logic [OP_WIDTH-1:0]   win_op;
  logic [DATA_WIDTH-1:0] win_a;
  logic [DATA_WIDTH-1:0] win_b;
  logic                  accept;
  logic                  rsp_done;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  localparam logic [ID_WIDTH:0] NUM_REQ_W = (ID_WIDTH+1)'(NUM_REQ);

  logic [ID_WIDTH-1:0]   rr_ptr_q;
  logic [2*NUM_REQ-1:0]  vld_dbl;
  logic [NUM_REQ-1:0]    vld_rot;
  logic [ID_WIDTH:0]     win_sum;
  logic [ID_WIDTH:0]     ptr_nxt;

  // Rotate the request vector so the pointer lands at bit 0, then take the lowest set bit.
  always_comb begin
    vld_dbl = {req_valid_i, req_valid_i} >> rr_ptr_q;
    vld_rot = vld_dbl[NUM_REQ-1:0];
    any_vld = |req_valid_i;
    win_sum = {1'b0, rr_ptr_q};
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (vld_rot[j]) win_sum = {1'b0, rr_ptr_q} + (ID_WIDTH+1)'(j);
    end
    if (win_sum >= NUM_REQ_W) win_sum = win_sum - NUM_REQ_W;
    win_id  = win_sum[ID_WIDTH-1:0];
    ptr_nxt = {1'b0, win_id} + (ID_WIDTH+1)'(1);
    if (ptr_nxt == NUM_REQ_W) ptr_nxt = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q <= '0;
    end else if (accept) begin
      rr_ptr_q <= ptr_nxt[ID_WIDTH-1:0];
    end
  end
`else
  always_comb begin
    any_vld = |req_valid_i;
    win_id  = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req_valid_i[j]) win_id = ID_WIDTH'(j);
    end
  end
`endif

  always_comb begin
    win_oh   = '0;
    grant_oh = '0;
    win_op   = '0;
    win_a    = '0;
    win_b    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      win_oh[k]   = (win_id == ID_WIDTH'(k));
      grant_oh[k] = (grant_q == ID_WIDTH'(k));
      if (win_id == ID_WIDTH'(k)) begin
        win_op = req_op_i[k*OP_WIDTH +: OP_WIDTH];
        win_a  = req_a_i[k*DATA_WIDTH +: DATA_WIDTH];
        win_b  = req_b_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign accept   = (state_q == ST_IDLE) && any_vld;
  // Only the owner's ready can retire the response; other requesters' ready is ignored.
  assign rsp_done = (state_q == ST_RESP) && (|(rsp_ready_i & grant_oh));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            grant_q <= win_id;
            op_q    <= win_op;
            a_q     <= win_a;
            b_q     <= win_b;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          result_q <= alu_result_i;
          zero_q   <= alu_zero_i;
          state_q  <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_done) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o  = accept ? win_oh : '0;
  assign rsp_valid_o  = (state_q == ST_RESP) ? grant_oh : '0;
  assign rsp_result_o = result_q;
  assign rsp_zero_o   = zero_q;
  assign grant_id_o   = grant_q;
  assign busy_o       = (state_q == ST_EXEC) || (state_q == ST_RESP);
  assign alu_op_o     = op_q;
  assign alu_a_o      = a_q;
  assign alu_b_o      = b_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU on the alu_* ports and a response scoreboard.
module tb_alu_share_arbiter;

  localparam int NR = 2;
  localparam int DW = 32;
  localparam int OW = 4;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic reset;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*OW-1:0] req_op;
  logic [NR*DW-1:0] req_a;
  logic [NR*DW-1:0] req_b;
  logic [NR-1:0]    rsp_valid;
  logic [NR-1:0]    rsp_ready;
  logic [DW-1:0]    rsp_result;
  logic             rsp_zero;
  logic [IW-1:0]    grant_id;
  logic             busy;
  logic [OW-1:0]    alu_op;
  logic [DW-1:0]    alu_a;
  logic [DW-1:0]    alu_b;
  logic [DW-1:0]    alu_result;
  logic             alu_zero;

  alu_share_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .OP_WIDTH(OW), .ID_WIDTH(IW)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_a_i(req_a), .req_b_i(req_b),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_result_o(rsp_result), .rsp_zero_o(rsp_zero),
    .grant_id_o(grant_id), .busy_o(busy),
    .alu_op_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b),
    .alu_result_i(alu_result), .alu_zero_i(alu_zero)
  );

  always #5 clk = ~clk;

  // Stand-in ALU: ADD/SUB/AND/OR/XOR/SLL/SRL, LUI=B<<12, ORI=A|B, everything else 0.
  always_comb begin
    case (alu_op)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0001: alu_result = alu_a - alu_b;
      4'b0010: alu_result = alu_a & alu_b;
      4'b0011: alu_result = alu_a | alu_b;
      4'b0100: alu_result = alu_a ^ alu_b;
      4'b0101: alu_result = alu_a << alu_b[4:0];
      4'b0110: alu_result = alu_a >> alu_b[4:0];
      4'b1000: alu_result = alu_b << 12;
      4'b1001: alu_result = alu_a | alu_b;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  typedef struct {
    int          id;
    logic [31:0] res;
    logic        zero;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] oh(input int k);
    return 32'(1) << k;
  endfunction

  task automatic drive_req(input int k, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[k*OW +: OW] = op;
    req_a[k*DW +: DW]  = a;
    req_b[k*DW +: DW]  = b;
    req_valid[k]       = 1'b1;
  endtask

  // Waits for requester k to be granted, optionally records the expected response, then steps past the accept edge.
  task automatic accept(input int k, input logic [31:0] res, input logic z, input bit push, input bit drop);
    int n = 0;
    #1;
    while (req_ready[k] !== 1'b1 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("accept_in_time", 32'(n < 20), 32'd1);
    chk("req_ready_onehot", 32'(req_ready), oh(k));
    if (push) sb.push_back('{k, res, z});
    @(posedge clk); #1;
    if (drop) req_valid[k] = 1'b0;
  endtask

  // Checks the next response against the scoreboard, holding off rsp_ready for 'hold' cycles.
  task automatic respond(input int hold);
    exp_t e;
    int   n = 0;
    while (rsp_valid === '0 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("rsp_in_time", 32'(n < 20), 32'd1);
    chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk("rsp_valid", 32'(rsp_valid), oh(e.id));
    chk("rsp_result", rsp_result, e.res);
    chk("rsp_zero", 32'(rsp_zero), 32'(e.zero));
    chk("grant_id", 32'(grant_id), 32'(e.id));
    chk("busy_resp", 32'(busy), 32'd1);
    for (int h = 0; h < hold; h++) begin
      rsp_ready = NR'(oh(1 - e.id));
      @(negedge clk); #1;
      chk("hold_rsp_valid", 32'(rsp_valid), oh(e.id));
      chk("hold_result", rsp_result, e.res);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = NR'(oh(e.id));
    @(posedge clk); #1;
    rsp_ready = '0;
    chk("rsp_retired", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_gnt[4];
`ifdef ALU_ARB_ROUND_ROBIN_EN
    exp_gnt = '{0, 1, 0, 1};
`else
    exp_gnt = '{0, 0, 0, 0};
`endif
    reset = 1'b0; req_valid = '0; rsp_ready = '0;
    req_op = '0; req_a = '0; req_b = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_result", rsp_result, 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);

    // Reset while an ADD is executing: nothing may come back.
    drive_req(0, 4'b0000, 32'd5, 32'd7);
    accept(0, 32'd12, 1'b0, 1'b0, 1'b1);
    chk("exec_busy", 32'(busy), 32'd1);
    chk("exec_alu_a", alu_a, 32'd5);
    reset = 1'b0; #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_alu_a", alu_a, 32'd0);
    chk("midrst_alu_b", alu_b, 32'd0);
    chk("midrst_result", rsp_result, 32'd0);
    chk("midrst_zero", 32'(rsp_zero), 32'd0);
    chk("midrst_grant", 32'(grant_id), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk); @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("postrst_no_rsp", 32'(rsp_valid), 32'd0);
      chk("postrst_idle", 32'(busy), 32'd0);
    end

    // Single op from requester 1 with 2-cycle latency check.
    @(negedge clk);
    drive_req(1, 4'b0000, 32'h0000_0005, 32'hFFFF_FFFB);
    accept(1, 32'd0, 1'b1, 1'b1, 1'b1);
    chk("lat_exec_no_rsp", 32'(rsp_valid), 32'd0);
    chk("lat_exec_op", 32'(alu_op), 32'd0);
    @(posedge clk); #1;
    chk("lat_rsp_at_n2", 32'(rsp_valid), 32'b10);
    respond(0);

    // LUI and ORI pass-through.
    @(negedge clk);
    drive_req(0, 4'b1000, 32'h0000_0000, 32'h0001_2345);
    accept(0, 32'h1234_5000, 1'b0, 1'b1, 1'b1);
    respond(0);
    @(negedge clk);
    drive_req(1, 4'b1001, 32'h0000_00F0, 32'h0000_000F);
    accept(1, 32'h0000_00FF, 1'b0, 1'b1, 1'b1);
    respond(0);

    // Backpressure: response held 5 cycles while requester 0 waits.
    @(negedge clk);
    drive_req(1, 4'b0001, 32'd100, 32'd58);
    accept(1, 32'd42, 1'b0, 1'b1, 1'b1);
    drive_req(0, 4'b0100, 32'hAAAA_0000, 32'h0000_5555);
    respond(5);
    chk("bp_grant_next_idle", 32'(req_ready), 32'b01);
    accept(0, 32'hAAAA_5555, 1'b0, 1'b1, 1'b1);
    respond(0);

    // Undefined opcode completes normally with the ALU's default result.
    @(negedge clk);
    drive_req(0, 4'b0111, 32'd3, 32'd4);
    accept(0, 32'd0, 1'b1, 1'b1, 1'b1);
    respond(0);

    // Contention from a fresh reset so the round-robin pointer starts at 0.
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    drive_req(0, 4'b0000, 32'd10, 32'd20);
    drive_req(1, 4'b1001, 32'h100, 32'h1);
    for (int i = 0; i < 4; i++) begin
      int w;
      w = exp_gnt[i];
      accept(w, (w == 0) ? 32'd30 : 32'h101, 1'b0, 1'b1, 1'b0);
      if (i == 3) req_valid = '0;
      respond(0);
    end
    @(negedge clk); #1;
    chk("final_idle", 32'(busy), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
